// File: rtl/downsample_pool2.sv
// Streaming 2:1 decimator for channel-major Q8.8 frames.
// Each input pair produces one pooled word (average, signed max or keep-first).
// The pooled word sits in a one-entry registered output with valid/ready handshake.
module downsample_pool2 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned IN_LEN     = 16,
    parameter int unsigned MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OUT_LEN = IN_LEN / 2;
    localparam int unsigned PAIR_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SUM_W   = DATA_WIDTH + 1;

    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(OUT_LEN - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_SECOND = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [DATA_WIDTH-1:0] sample_a;
    logic [PAIR_W-1:0]     pair_cnt;
    logic [CH_W-1:0]       ch_cnt;
    logic [SUM_W-1:0]      pair_sum;
    logic [DATA_WIDTH-1:0] pooled;
    logic                  take_a;
    logic                  pair_done;
    logic                  pair_wrap;
    logic                  frame_last;

    assign take_a     = (state == S_FIRST) && valid_in;
    assign pair_done  = (state == S_SECOND) && valid_in && ready_in;
    assign pair_wrap  = (pair_cnt == PAIR_LAST);
    assign frame_last = pair_wrap && (ch_cnt == CH_LAST);

    // Next-state decode and combinational input ready.
    always_comb begin
        state_next = state;
        ready_in   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FIRST;
            end
            S_FIRST: begin
                ready_in = 1'b1;
                if (valid_in) state_next = S_SECOND;
            end
            S_SECOND: begin
                ready_in = !valid_out || ready_out;
                if (valid_in && ready_in) state_next = frame_last ? S_DRAIN : S_FIRST;
            end
            S_DRAIN: begin
                if (!valid_out || ready_out) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pooling op on the held sample A and the incoming sample B.
    always_comb begin
        // Sign-extended A+B+1; bits [DATA_WIDTH:1] are the half-up rounded mean.
        pair_sum = {sample_a[DATA_WIDTH-1], sample_a} + {data_in[DATA_WIDTH-1], data_in} + SUM_W'(1);
        if (MODE == 0) begin
            pooled = DATA_WIDTH'(pair_sum >> 1);
        end else if (MODE == 1) begin
            pooled = ($signed(data_in) > $signed(sample_a)) ? data_in : sample_a;
        end else begin
            pooled = sample_a;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Held sample A and the pair/channel position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_a <= '0;
            pair_cnt <= '0;
            ch_cnt   <= '0;
        end else begin
            if (take_a) sample_a <= data_in;
            if ((state == S_IDLE) || (state == S_DONE)) begin
                pair_cnt <= '0;
                ch_cnt   <= '0;
            end else if (pair_done) begin
                if (pair_wrap) begin
                    pair_cnt <= '0;
                    ch_cnt   <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);
                end else begin
                    pair_cnt <= pair_cnt + PAIR_W'(1);
                end
            end
        end
    end

    // One-entry output register; a load may coincide with the drain of the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (pair_done) begin
            data_out  <= pooled;
            valid_out <= 1'b1;
            last_out  <= pair_wrap;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

    // Frame status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_FIRST) || (state_next == S_SECOND) || (state_next == S_DRAIN);
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_downsample_pool2.sv
// Bench for downsample_pool2: one default instance plus three single-channel
// IN_LEN=4 instances (one per pooling mode) sharing the input stream.
`timescale 1ns/1ps
module tb_downsample_pool2;

    localparam int DW  = 16;
    localparam int NI  = 4;
    localparam int IB  = 0;
    localparam int IS0 = 1;
    localparam int IM1 = 2;
    localparam int IM2 = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_b;
    logic          start_s;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] data_in;

    wire [DW-1:0] dout [NI];
    wire          vout [NI];
    wire          lout [NI];
    wire          bsy  [NI];
    wire          dn   [NI];
    wire          rin  [NI];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW:0]   exp_q [NI][$];
    logic [DW:0]   obs_q [NI][$];
    int            n_out [NI];
    int            n_done [NI];
    int            hs_cyc [NI];
    logic          prev_stall [NI];
    logic [DW:0]   prev_word [NI];
    logic          b_active;
    int            stall_acc;
    int            ro_mode;
    int            stall_left;
    logic          stall_armed;
    logic [DW-1:0] in_q [$];

    always #5 clk = ~clk;

    downsample_pool2 #(.DATA_WIDTH(DW), .CHANNELS(4), .IN_LEN(16), .MODE(0)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rin[IB]), .data_out(dout[IB]), .valid_out(vout[IB]), .ready_out(ready_out),
        .last_out(lout[IB]), .busy(bsy[IB]), .done(dn[IB]));

    downsample_pool2 #(.DATA_WIDTH(DW), .CHANNELS(1), .IN_LEN(4), .MODE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rin[IS0]), .data_out(dout[IS0]), .valid_out(vout[IS0]), .ready_out(ready_out),
        .last_out(lout[IS0]), .busy(bsy[IS0]), .done(dn[IS0]));

    downsample_pool2 #(.DATA_WIDTH(DW), .CHANNELS(1), .IN_LEN(4), .MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rin[IM1]), .data_out(dout[IM1]), .valid_out(vout[IM1]), .ready_out(ready_out),
        .last_out(lout[IM1]), .busy(bsy[IM1]), .done(dn[IM1]));

    downsample_pool2 #(.DATA_WIDTH(DW), .CHANNELS(1), .IN_LEN(4), .MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rin[IM2]), .data_out(dout[IM2]), .valid_out(vout[IM2]), .ready_out(ready_out),
        .last_out(lout[IM2]), .busy(bsy[IM2]), .done(dn[IM2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Reference pooling from plain integer arithmetic.
    function automatic logic [DW-1:0] pool(input int mode, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sa;
        int sb;
        int s;
        int q;
        sa = $signed(a);
        sb = $signed(b);
        if (mode == 0) begin
            s = sa + sb + 1;
            q = s / 2;
            if (s < 0 && (s % 2) != 0) q = q - 1;
            return 16'(q);
        end else if (mode == 1) begin
            return (sb > sa) ? b : a;
        end
        return a;
    endfunction

    task automatic expect_frame(input int idx, input int mode, input int out_len);
        for (int k = 0; k < in_q.size() / 2; k++) begin
            exp_q[idx].push_back({((k % out_len) == out_len - 1), pool(mode, in_q[2*k], in_q[2*k+1])});
        end
    endtask

    // Output scoreboard, hold checks, done timing and busy model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            b_active = 1'b0;
            for (int i = 0; i < NI; i++) prev_stall[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (prev_stall[i]) begin
                    check($sformatf("hold_valid[%0d]", i), 32'(vout[i]), 32'd1);
                    check($sformatf("hold_word[%0d]", i), 32'({lout[i], dout[i]}), 32'(prev_word[i]));
                end
                if (vout[i] && ready_out) begin
                    n_out[i]++;
                    hs_cyc[i] = cyc;
                    obs_q[i].push_back({lout[i], dout[i]});
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL out_extra[%0d]: got 0x%0h want none at cycle %0d", i, {lout[i], dout[i]}, cyc);
                    end else begin
                        check($sformatf("out_word[%0d]#%0d", i, n_out[i]), 32'({lout[i], dout[i]}), 32'(exp_q[i].pop_front()));
                    end
                end
                if (dn[i]) begin
                    n_done[i]++;
                    check($sformatf("done_timing[%0d]", i), 32'(cyc), 32'(hs_cyc[i] + 1));
                end
                prev_stall[i] = vout[i] && !ready_out;
                prev_word[i]  = {lout[i], dout[i]};
            end
            check("busy_big", 32'(bsy[IB]), dn[IB] ? 32'd0 : 32'(b_active));
            if (dn[IB]) b_active = 1'b0;
            else if (!b_active && start_b) b_active = 1'b1;
            if (vout[IS0] && !ready_out && valid_in && rin[IS0]) stall_acc++;
        end
    end

    // Downstream ready patterns.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ro_mode)
                1: ready_out = ($urandom_range(0, 99) < 70);
                2: begin
                    if (stall_left > 0) begin
                        ready_out = 1'b0;
                        stall_left--;
                    end else if (stall_armed && vout[IS0]) begin
                        ready_out   = 1'b0;
                        stall_left  = 4;
                        stall_armed = 1'b0;
                    end else begin
                        ready_out = 1'b1;
                    end
                end
                3: ready_out = 1'b0;
                4: ready_out = (n_out[IB] == 0);
                default: ready_out = 1'b1;
            endcase
        end
    end

    task automatic pulse_start(input int grp);
        @(posedge clk); #1;
        if (grp == 0) start_b = 1'b1;
        else          start_s = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic send(input int idx, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < in_q.size() && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                valid_in = 1'b0;
                data_in  = 16'hDEAD;
            end else begin
                valid_in = 1'b1;
                data_in  = in_q[i];
            end
            @(negedge clk);
            if (valid_in && rin[idx]) i++;
        end
        check($sformatf("inputs_accepted[%0d]", idx), 32'(i), 32'(in_q.size()));
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int t = 0;
        while (!dn[idx] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("done_seen[%0d]", idx), 32'(dn[idx]), 32'd1);
        @(negedge clk);
    endtask

    task automatic small_frame(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                               input logic [DW-1:0] a2, input logic [DW-1:0] a3, input int gap);
        in_q.delete();
        in_q.push_back(a0);
        in_q.push_back(a1);
        in_q.push_back(a2);
        in_q.push_back(a3);
        for (int m = 0; m < 3; m++) begin
            obs_q[IS0+m].delete();
            n_out[IS0+m] = 0;
            expect_frame(IS0 + m, m, 2);
        end
        pulse_start(1);
        send(IS0, gap);
        wait_done(IS0);
        for (int m = 0; m < 3; m++) begin
            check($sformatf("small_out_count[%0d]", IS0 + m), 32'(n_out[IS0+m]), 32'd2);
            check($sformatf("small_pending[%0d]", IS0 + m), 32'(exp_q[IS0+m].size()), 32'd0);
        end
    endtask

    task automatic lit(input string name, input int idx, input int k, input logic [DW:0] want);
        logic [DW:0] w;
        w = (k < obs_q[idx].size()) ? obs_q[idx][k] : 17'h1_FFFF;
        check(name, 32'(w), 32'(want));
    endtask

    task automatic big_frame(input int gap, input logic spurious);
        in_q.delete();
        for (int k = 0; k < 64; k++) in_q.push_back(16'($urandom()));
        obs_q[IB].delete();
        n_out[IB] = 0;
        expect_frame(IB, 0, 8);
        pulse_start(0);
        fork
            send(IB, gap);
            if (spurious) begin
                for (int p = 0; p < 3; p++) begin
                    repeat (10 + 10 * p) @(posedge clk);
                    #1 start_b = 1'b1;
                    @(posedge clk); #1 start_b = 1'b0;
                end
            end
        join
        wait_done(IB);
        check("big_out_count", 32'(n_out[IB]), 32'd32);
        check("big_pending", 32'(exp_q[IB].size()), 32'd0);
        for (int k = 7; k < 32; k += 8) lit($sformatf("big_last_at_%0d", k + 1), IB, k, {1'b1, pool(0, in_q[2*k], in_q[2*k+1])});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_b = 1'b0; start_s = 1'b0; valid_in = 1'b0; data_in = '0;
        ro_mode = 0; stall_left = 0; stall_armed = 1'b0; stall_acc = 0; b_active = 1'b0;
        for (int i = 0; i < NI; i++) begin
            n_out[i] = 0; n_done[i] = 0; hs_cyc[i] = -100; prev_stall[i] = 1'b0; prev_word[i] = '0;
        end
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_data[%0d]", i), 32'(dout[i]), 32'd0);
            check($sformatf("rst_valid[%0d]", i), 32'(vout[i]), 32'd0);
            check($sformatf("rst_flags[%0d]", i), 32'({lout[i], bsy[i], dn[i], rin[i]}), 32'd0);
        end
        rst_n = 1'b1;

        // Directed single-channel frames with hand-computed results.
        small_frame(16'h0100, 16'h0300, 16'h0080, 16'h0081, 0);
        lit("avg_0100_0300", IS0, 0, 17'h0_0200);
        lit("avg_0080_0081_last", IS0, 1, 17'h1_0081);
        small_frame(16'hFFFF, 16'h0000, 16'h7FFF, 16'h7FFF, 0);
        lit("avg_ffff_0000", IS0, 0, 17'h0_0000);
        lit("avg_7fff_7fff", IS0, 1, 17'h1_7FFF);
        small_frame(16'h8000, 16'h8000, 16'hFFFE, 16'hFFFF, 0);
        lit("avg_8000_8000", IS0, 0, 17'h0_8000);
        lit("avg_fffe_ffff", IS0, 1, 17'h1_FFFF);
        small_frame(16'hFF00, 16'h0080, 16'h8000, 16'hFFFF, 0);
        lit("max_ff00_0080", IM1, 0, 17'h0_0080);
        lit("max_8000_ffff", IM1, 1, 17'h1_FFFF);
        small_frame(16'h1234, 16'h5678, 16'h0001, 16'hFFFF, 30);
        lit("first_1234_5678", IM2, 0, 17'h0_1234);
        lit("first_0001_ffff", IM2, 1, 17'h1_0001);

        // Five-cycle downstream stall after the first output.
        ro_mode = 2; stall_armed = 1'b1; stall_acc = 0;
        small_frame(16'h0400, 16'h0200, 16'hFF80, 16'h0100, 0);
        lit("stall_avg0", IS0, 0, 17'h0_0300);
        lit("stall_avg1", IS0, 1, 17'h1_0040);
        check("inputs_during_stall", 32'(stall_acc), 32'd1);
        ro_mode = 0;

        // Full frame with random gaps and ignored start pulses.
        ro_mode = 1;
        big_frame(30, 1'b1);

        // Abort mid-frame with a word held in the output register.
        ro_mode = 4;
        in_q.delete();
        for (int k = 0; k < 5; k++) in_q.push_back(16'($urandom()) | 16'h0101);
        n_out[IB] = 0;
        exp_q[IB].push_back({1'b0, pool(0, in_q[0], in_q[1])});
        pulse_start(0);
        send(IB, 0);
        @(negedge clk);
        check("pre_rst_valid", 32'(vout[IB]), 32'd1);
        check("pre_rst_busy", 32'(bsy[IB]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(dout[IB]), 32'd0);
        check("async_rst_valid", 32'(vout[IB]), 32'd0);
        check("async_rst_flags", 32'({lout[IB], bsy[IB], dn[IB], rin[IB]}), 32'd0);
        check("aborted_out_count", 32'(n_out[IB]), 32'd1);
        exp_q[IB].delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Fresh frame after the abort.
        ro_mode = 1;
        big_frame(20, 1'b0);
        ro_mode = 0;

        check("done_pulses_big", 32'(n_done[IB]), 32'd2);
        for (int i = IS0; i <= IM2; i++) check($sformatf("done_pulses[%0d]", i), 32'(n_done[i]), 32'd6);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/downsample_pool2.md
Name: downsample_pool2

Overview:
- Streaming 2:1 temporal decimator for Q8.8 feature maps; the inverse of the 2x nearest-neighbour upsampler stage.
- Sits in the discriminator/encoder path and consumes channel-major frames: the full IN_LEN samples of channel 0, then channel 1, and so on.
- Emits one pooled sample per input pair, by average, max or keep-first, behind a one-entry registered output with valid/ready backpressure.

Parameters:
- DATA_WIDTH, 16, sample width, signed Q8.8.
- CHANNELS, 4, channels per frame.
- IN_LEN, 16, input samples per channel; must be even and ≥2. OUT_LEN = IN_LEN/2.
- MODE, 0, pooling op: 0 = average (rounded), 1 = signed max, 2 = keep first of each pair.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a frame when idle
- data_in  in  DATA_WIDTH  signed input sample
- valid_in  in  1  input valid
- ready_in  out  1  input ready (combinational)
- data_out  out  DATA_WIDTH  signed pooled sample (registered)
- valid_out  out  1  output valid (registered)
- ready_out  in  1  downstream ready
- last_out  out  1  high with the final output word of each channel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. Reset drives state to IDLE, clears all counters and the held sample, and sets data_out=0, valid_out=0, last_out=0, busy=0, done=0. Assertion mid-frame aborts immediately; the partial frame is discarded.
- States: IDLE, FIRST, SECOND, DRAIN, DONE.
  - IDLE: ready_in=0. start → FIRST. No sample is consumed on the start cycle.
  - FIRST: ready_in=1. On valid_in&&ready_in, latch sample A → SECOND.
  - SECOND: ready_in = !valid_out || ready_out. On valid_in&&ready_in, compute result from A and the incoming sample B and load the output register.
    - If this was the last pair of the last channel → DRAIN; else → FIRST.
  - DRAIN: ready_in=0. Wait until valid_out&&ready_out, or valid_out already 0 → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- busy = state ∈ {FIRST, SECOND, DRAIN}. start is ignored unless in IDLE.
- Output register:
  - Loaded the cycle after the pair completes, so latency from the B handshake to valid_out=1 is 1 cycle.
  - A load and a drain can occur in the same cycle; this gives full throughput of 1 output per 2 accepted inputs.
  - valid_out clears on valid_out&&ready_out when no new load occurs in that cycle.
  - data_out and last_out are held stable while valid_out&&!ready_out.
- Arithmetic:
  - MODE 0: 17-bit sign-extended sum S=A+B; result = (S+1)>>>1, truncated to DATA_WIDTH. This rounds half toward +inf and cannot overflow.
  - MODE 1: signed compare; result = (B>A) ? B : A.
  - MODE 2: result = A; B is consumed and discarded.
- Counters:
  - pair_cnt counts 0..OUT_LEN-1. On wrap it returns to 0 and ch_cnt increments, 0..CHANNELS-1.
  - Each counter is at least 1 bit wide.
  - last_out = 1 on the word where pair_cnt == OUT_LEN-1.
  - Both counters clear in IDLE and DONE.
- Stalls: valid_in low in FIRST or SECOND simply waits, with state, counters and A held. Downstream stall backpressures only in SECOND and DRAIN.
- Total per frame: CHANNELS*IN_LEN inputs accepted, CHANNELS*OUT_LEN outputs emitted, exactly one done pulse.

Test Plan:
- MODE0, CHANNELS=1, IN_LEN=4, ready_out=1, inputs 0x0100,0x0300,0x0080,0x0081 → outputs 0x0200, 0x0081; last_out=1 on the second output; done pulses one cycle after the second output handshake.
- MODE0 boundary pairs:
  - (0xFFFF,0x0000) → 0x0000
  - (0x7FFF,0x7FFF) → 0x7FFF
  - (0x8000,0x8000) → 0x8000
  - (0xFFFE,0xFFFF) → 0xFFFF
- MODE1: (0xFF00,0x0080) → 0x0080; (0x8000,0xFFFF) → 0xFFFF. MODE2: (0x1234,0x5678) → 0x1234.
- Backpressure: ready_out=0 for 5 cycles after the first output. Required: data_out stable, ready_in=0 in SECOND, no sample lost. After release, the full frame output equals the golden model.
- Default params, random valid_in/ready_out gaps, 64 inputs:
  - 32 outputs;
  - last_out on outputs 8, 16, 24 and 32 (1-based);
  - busy high from the cycle after start until DONE;
  - start pulses while busy are ignored.
- Reset at mid-frame (after 5 inputs) with valid_out=1 → all outputs 0 asynchronously. A new start then processes a fresh frame correctly, with no residue of the old A sample or counters.
